// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a DEPTH-entry instruction queue.
// Optional macro FETCH_ALIGN_CHECK_EN adds the one-cycle misalign output for misaligned redirect targets.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [29:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   inst_pc_q, inst_pc_d;
    logic          valid_q, valid_d;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic [CW-1:0] cnt_after_push_s;
    logic [31:0]   redirect_tgt_s;

    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

    // Fetch FSM: next state, fetch PC and queue push/flush requests.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        pop_s      = valid_q & inst_ready & ~redirect;
        if (pop_s) begin
            cnt_after_push_s = count_q;
        end else begin
            cnt_after_push_s = count_q + CNT_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_d = redirect_tgt_s;
                end else if (count_q < DEPTH_C) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_d = redirect_tgt_s;
                    state_d    = imem_ack ? ST_IDLE : ST_FLUSH;
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (cnt_after_push_s < DEPTH_C) ? ST_BUSY : ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FLUSH: begin
                // The abandoned request stays on the bus until memory answers it.
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_d = redirect_tgt_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                state_d = imem_ack ? ST_IDLE : ST_FLUSH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = {fetch_pc_q, imem_data};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Head-of-queue output registers, computed from the post-edge queue so they are valid with no bypass.
    always_comb begin
        valid_d = (count_d != {CW{1'b0}});
        if (valid_d) begin
            inst_d    = mem_d[rd_ptr_d][31:0];
            inst_pc_d = mem_d[rd_ptr_d][63:32];
        end else begin
            inst_d    = 32'h0;
            inst_pc_d = 32'h0;
        end
    end

    // Request address: refreshed only when (re)entering or continuing BUSY, held otherwise.
    always_comb begin
        if (state_d == ST_BUSY) begin
            addr_d = fetch_pc_d[31:2];
        end else begin
            addr_d = addr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC[31:2];
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
            valid_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 64'h0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            mem_q      <= mem_d;
        end
    end

    assign imem_req   = (state_q == ST_BUSY) || (state_q == ST_FLUSH);
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // Misaligned redirect target flag, one cycle per offending redirect edge.
    always_comb begin
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = 1'b0;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit: a program-order model predicts the delivered
// instruction stream; a negedge monitor compares every pop against the expected queue.
module tb_inst_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: program-order stream of PCs the consumer must see.
    logic [31:0] exp_q[$];
    logic [31:0] fetch_ptr;
    logic        stale;
    logic        smp_req;
    logic        app_ack, app_redirect;
    logic [31:0] app_rpc;

    int ack_pct, ready_pct, redir_pct, ack_delay, wait_cnt;

    logic        mon_en    = 1'b0;
    logic        mon_fresh = 1'b1;
    logic        prev_req, prev_ack;
    logic [29:0] prev_addr;
    logic [31:0] mon_e;

    function automatic logic [31:0] pat(input logic [31:0] pc);
        logic [31:0] p;
        p = pc * 32'h9E37_79B1;
        return p ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Account for what the DUT should have done on the edge just passed.
    task automatic commit();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign", 64'(misalign), 64'(app_redirect && (app_rpc[1:0] != 2'b00)));
`endif
        if (app_redirect) begin
            exp_q.delete();
            fetch_ptr = app_rpc & 32'hFFFF_FFFC;
            if (smp_req) stale = !app_ack;
        end else if (smp_req && app_ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                exp_q.push_back(fetch_ptr);
                fetch_ptr = fetch_ptr + 32'd4;
            end
        end
    endtask

    task automatic decide();
        logic        a, r;
        logic [31:0] rpc;
        smp_req = imem_req;
        if (imem_req && !stale) chk("imem_addr", 64'(imem_addr), 64'(fetch_ptr[31:2]));
        if (ack_delay < 0) begin
            a = ($urandom_range(0, 99) < ack_pct);
        end else if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                a = 1'b1;
                wait_cnt = 0;
            end else begin
                a = 1'b0;
                wait_cnt++;
            end
        end else begin
            a = 1'b0;
            wait_cnt = 0;
        end
        r   = ($urandom_range(0, 99) < redir_pct);
        rpc = $urandom;
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
        imem_ack     = a;
        imem_data    = pat({imem_addr, 2'b00});
        inst_ready   = ($urandom_range(0, 99) < ready_pct);
        redirect     = r;
        redirect_pc  = rpc;
        app_ack      = a;
        app_redirect = r;
        app_rpc      = rpc;
    endtask

    task automatic cycle();
        @(posedge clock);
        #2;
        commit();
        decide();
    endtask

    task automatic do_reset(input int n);
        #1;
        mon_en      = 1'b0;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b1;
        imem_data   = 32'hDEAD_BEEF;
        inst_ready  = 1'b1;
        #1;
        chk("rst_req",   64'(imem_req),   64'(1'b0));
        chk("rst_valid", 64'(inst_valid), 64'(1'b0));
        chk("rst_inst",  64'({inst_pc, inst}), 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", 64'(misalign), 64'(1'b0));
`endif
        exp_q.delete();
        fetch_ptr    = RESET_PC;
        stale        = 1'b0;
        smp_req      = 1'b0;
        app_ack      = 1'b0;
        app_redirect = 1'b0;
        app_rpc      = 32'h0;
        wait_cnt     = 0;
        repeat (n) @(posedge clock);
        #3;
        reset     = 1'b1;
        mon_fresh = 1'b1;
        mon_en    = 1'b1;
    endtask

    // Monitor: queue-state, idle-output, hold-stability and popped-instruction checks.
    always @(negedge clock) begin
        if (mon_en) begin
            if (!mon_fresh && prev_req && !prev_ack) begin
                chk("req_held",  64'(imem_req),  64'(1'b1));
                chk("addr_held", 64'(imem_addr), 64'(prev_addr));
            end
            chk("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
            if (!inst_valid) chk("idle_zero", 64'({inst_pc, inst}), 64'h0);
            if (inst_valid && inst_ready && !redirect && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("inst_pc", 64'(inst_pc), 64'(mon_e));
                chk("inst",    64'(inst),    64'(pat(mon_e)));
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            mon_fresh = 1'b0;
        end
    end

    initial begin
        logic found;
        reset     = 1'b0;
        ack_pct   = 100;
        ready_pct = 100;
        redir_pct = 0;
        ack_delay = -1;

        // Zero-wait memory, always-ready consumer: one instruction per cycle.
        do_reset(2);
        cycle();
        chk("first_req",    64'(imem_req),   64'(1'b1));
        chk("first_addr",   64'(imem_addr),  64'(RESET_PC[31:2]));
        chk("first_novalid", 64'(inst_valid), 64'(1'b0));
        cycle();
        chk("first_valid",  64'(inst_valid), 64'(1'b1));
        chk("first_pc",     64'(inst_pc),    64'(RESET_PC));
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("throughput", 64'(inst_valid), 64'(1'b1));
        end

        // Stalled consumer: queue fills, fetch stops, then drains and resumes.
        do_reset(1);
        ready_pct = 0;
        repeat (10) cycle();
        chk("full_noreq",  64'(imem_req),   64'(1'b0));
        chk("full_valid",  64'(inst_valid), 64'(1'b1));
        chk("full_headpc", 64'(inst_pc),    64'(32'h0));
        ready_pct = 100;
        repeat (12) cycle();

        // Three-cycle memory latency.
        ack_delay = 3;
        repeat (40) cycle();

        // Redirect while the request for 0x8 is pending.
        do_reset(1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (imem_req && imem_addr == 30'h2) found = 1'b1;
        end
        chk("saw_req_0x8", 64'(found), 64'(1'b1));
        imem_ack     = 1'b0;
        app_ack      = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 32'h100;
        app_redirect = 1'b1;
        app_rpc      = 32'h100;
        cycle();
        chk("flush_req",   64'(imem_req),   64'(1'b1));
        chk("flush_empty", 64'(inst_valid), 64'(1'b0));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (imem_req && imem_addr == 30'h40) found = 1'b1;
        end
        chk("restart_0x100", 64'(found), 64'(1'b1));
        repeat (10) cycle();

        // Randomized traffic with redirects, partial stalls and a mid-run reset.
        ack_delay = -1;
        ack_pct   = 60;
        ready_pct = 60;
        redir_pct = 4;
        repeat (1500) cycle();
        do_reset(3);
        ready_pct = 25;
        ack_pct   = 80;
        repeat (1500) cycle();
        redir_pct = 0;
        ready_pct = 100;
        ack_pct   = 100;
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
